// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: picks one of N_SRC write-back sources per cycle.
// Latency: request sampled at edge t yields gnt/src_sel/reg_waddr/reg_write registered at edge t.
// Backpressure: hold freezes new grants; pending requests stay queued on req, nothing is dropped.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req[N_SRC]        per-source write request, held until the matching gnt is seen
//   waddr_flat        destination register of source i at [i*AW +: AW]
//   hold              control-unit freeze, blocks new grants while high
//   gnt               one-cycle one-hot grant pulse
//   src_sel           SrcData mux select (0..N_SRC-1), holds when idle
//   reg_write         register bank write enable (suppressed for $0)
//   reg_waddr         register bank write address, holds when idle
//   busy              any request pending or a grant issued this cycle (combinational)
module wb_port_arbiter #(
    parameter int N_SRC      = 9,
    parameter int SEL_W      = 4,
    parameter int AW         = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      req,
    input  logic [N_SRC*AW-1:0]   waddr_flat,
    input  logic                  hold,
    output logic [N_SRC-1:0]      gnt,
    output logic [SEL_W-1:0]      src_sel,
    output logic                  reg_write,
    output logic [AW-1:0]         reg_waddr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_ptr;
    logic [N_SRC-1:0]     r_gnt;
    logic [SEL_W-1:0]     r_src_sel;
    logic                 r_reg_write;
    logic [AW-1:0]        r_reg_waddr;

    logic [N_SRC-1:0]     w_elig;
    logic                 w_found;
    logic [SEL_W-1:0]     w_win;
    logic [SEL_W-1:0]     w_ptr_nxt;
    logic [N_SRC-1:0]     w_onehot;
    logic [AW-1:0]        w_waddr [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_waddr
        assign w_waddr[i] = waddr_flat[i*AW +: AW];
    end

    // Rotated search index: (p + k) mod N_SRC without a divider, valid for p, k < N_SRC.
    function automatic int rr_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N_SRC) ? s - N_SRC : s;
    endfunction

    // A requester whose grant is visible this cycle still has req high; masking it
    // with the registered grant makes one request produce exactly one grant.
    assign w_elig = req & ~r_gnt;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        if (FIXED_PRIO != 0) begin
            // Descending scan so the lowest eligible index is the last one written.
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_found = 1'b1;
                    w_win   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N_SRC; k++) begin
                if (!w_found && w_elig[rr_idx(int'(r_ptr), k)]) begin
                    w_found = 1'b1;
                    w_win   = SEL_W'(rr_idx(int'(r_ptr), k));
                end
            end
        end
    end

    assign w_ptr_nxt = (w_win == SEL_W'(N_SRC - 1)) ? '0 : w_win + 1'b1;
    assign w_onehot  = N_SRC'(1) << w_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_src_sel   <= '0;
            r_reg_write <= 1'b0;
            r_reg_waddr <= '0;
        end else if (!hold && w_found) begin
            // Transition into ISSUE is the same from IDLE, ISSUE or FROZEN, so a
            // hold release with requests waiting arbitrates at that very edge.
            r_state     <= ISSUE;
            r_gnt       <= w_onehot;
            r_src_sel   <= w_win;
            r_reg_waddr <= w_waddr[w_win];
            // $0 is hard-wired zero: grant the source but never strobe the bank.
            r_reg_write <= |w_waddr[w_win];
            if (FIXED_PRIO == 0) begin
                r_ptr <= w_ptr_nxt;
            end
        end else begin
            r_state     <= hold ? FROZEN : IDLE;
            r_gnt       <= '0;
            r_reg_write <= 1'b0;
            // src_sel / reg_waddr keep their value so the mux does not glitch.
        end
    end

    assign gnt       = r_gnt;
    assign src_sel   = r_src_sel;
    assign reg_write = r_reg_write;
    assign reg_waddr = r_reg_waddr;
    assign busy      = (|req) | (r_state == ISSUE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int N  = 9;
    localparam int AW = 5;

    logic            clk;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req_rr;
    logic [N-1:0]    req_fp;
    logic [N*AW-1:0] waddr_flat;

    logic [N-1:0]    rr_gnt,  fp_gnt;
    logic [3:0]      rr_sel,  fp_sel;
    logic            rr_wr,   fp_wr;
    logic [AW-1:0]   rr_wa,   fp_wa;
    logic            rr_busy, fp_busy;

    wb_port_arbiter #(.N_SRC(N), .SEL_W(4), .AW(AW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset), .req(req_rr), .waddr_flat(waddr_flat), .hold(hold),
        .gnt(rr_gnt), .src_sel(rr_sel), .reg_write(rr_wr), .reg_waddr(rr_wa), .busy(rr_busy)
    );

    wb_port_arbiter #(.N_SRC(N), .SEL_W(4), .AW(AW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .req(req_fp), .waddr_flat(waddr_flat), .hold(hold),
        .gnt(fp_gnt), .src_sel(fp_sel), .reg_write(fp_wr), .reg_waddr(fp_wa), .busy(fp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          sel;
        logic [4:0]  wa;
        logic        wr;
    } exp_t;

    exp_t        q_rr[$];
    exp_t        q_fp[$];
    logic [4:0]  wa [N];
    int          fp_ord [10];
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected grant of source sel on instance inst, registered at edge number at.
    task automatic push(input int inst, input int at, input int sel);
        exp_t e;
        e.cyc = at;
        e.sel = sel;
        e.wa  = wa[sel];
        e.wr  = (wa[sel] != 5'd0);
        if (inst == 0) q_rr.push_back(e);
        else           q_fp.push_back(e);
    endtask

    task automatic observe(input string tag, input int inst, input logic [N-1:0] g,
                           input logic [3:0] s, input logic [4:0] a, input logic w);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (inst == 0) begin
            if (q_rr.size() > 0 && q_rr[0].cyc == cyc) begin
                e = q_rr.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q_fp.size() > 0 && q_fp[0].cyc == cyc) begin
                e = q_fp.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            chk({tag, ".gnt"},       32'(g), 32'(1) << e.sel);
            chk({tag, ".src_sel"},   32'(s), 32'(e.sel));
            chk({tag, ".reg_waddr"}, 32'(a), 32'(e.wa));
            chk({tag, ".reg_write"}, 32'(w), 32'(e.wr));
        end else begin
            chk({tag, ".gnt_idle"},  32'(g), 32'd0);
            chk({tag, ".wr_idle"},   32'(w), 32'd0);
        end
    endtask

    // Advance one clock, then sample both instances 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        observe("rr", 0, rr_gnt, rr_sel, rr_wa, rr_wr);
        observe("fp", 1, fp_gnt, fp_sel, fp_wa, fp_wr);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset  = 1'b1;
        hold   = 1'b0;
        req_rr = '0;
        req_fp = '0;
        wa[0] = 5'd17; wa[1] = 5'd1;  wa[2] = 5'd8;  wa[3] = 5'd3; wa[4] = 5'd0;
        wa[5] = 5'd21; wa[6] = 5'd6;  wa[7] = 5'd30; wa[8] = 5'd31;
        fp_ord = '{0, 1, 2, 3, 4, 0, 5, 6, 7, 8};
        for (int i = 0; i < N; i++) waddr_flat[i*AW +: AW] = wa[i];

        // Reset held for three cycles, then ten idle cycles.
        repeat (3) begin
            step();
            chk("rst.src_sel",   32'(rr_sel),  32'd0);
            chk("rst.reg_waddr", 32'(rr_wa),   32'd0);
            chk("rst.busy",      32'(rr_busy), 32'd0);
        end
        reset = 1'b0;
        repeat (10) begin
            step();
            chk("idle.busy",    32'(rr_busy), 32'd0);
            chk("idle.src_sel", 32'(rr_sel),  32'd0);
        end

        // Single request on source 2; req stays high one more cycle -> no second grant.
        req_rr[2] = 1'b1;
        push(0, cyc + 1, 2);
        step();
        chk("single.busy", 32'(rr_busy), 32'd1);
        step();
        req_rr[2] = 1'b0;
        step();

        // Write to $0 is granted but not strobed.
        req_rr[4] = 1'b1;
        push(0, cyc + 1, 4);
        step();
        req_rr[4] = 1'b0;
        step();

        // Asynchronous reset in the middle of a write cycle.
        req_rr[7] = 1'b1;
        push(0, cyc + 1, 7);
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst.reg_write", 32'(rr_wr),  32'd0);
        chk("arst.gnt",       32'(rr_gnt), 32'd0);
        chk("arst.src_sel",   32'(rr_sel), 32'd0);
        chk("arst.reg_waddr", 32'(rr_wa),  32'd0);
        #1 reset = 1'b0;
        // Pointer back at 0: 3 must beat 7.
        req_rr = 9'h088;
        push(0, cyc + 1, 3);
        push(0, cyc + 2, 7);
        step();
        req_rr[3] = 1'b0;
        step();
        req_rr[7] = 1'b0;
        step();

        // Requests raised under hold wait; release arbitrates at that edge (ptr at 8).
        hold   = 1'b1;
        req_rr = 9'h042;
        repeat (4) begin
            step();
            chk("hold.src_sel", 32'(rr_sel),  32'd7);
            chk("hold.busy",    32'(rr_busy), 32'd1);
        end
        hold = 1'b0;
        push(0, cyc + 1, 1);
        push(0, cyc + 2, 6);
        step();
        req_rr[1] = 1'b0;
        step();
        req_rr[6] = 1'b0;
        step();

        // Reset pulse to restart the pointer, then round-robin wrap with all requesting.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_rr = 9'h1FF;
        for (int k = 0; k < 11; k++) push(0, cyc + 1 + k, k % 9);
        repeat (11) step();
        req_rr = '0;
        step();
        step();
        chk("rr_done.busy", 32'(rr_busy), 32'd0);

        // Fixed priority: each requester drops on its grant; 0 re-requests after grant 4.
        req_fp = 9'h1FF;
        for (int k = 0; k < 10; k++) push(1, cyc + 1 + k, fp_ord[k]);
        for (int k = 0; k < 10; k++) begin
            step();
            req_fp = req_fp & ~fp_gnt;
            if (k == 4) req_fp[0] = 1'b1;
        end
        step();
        step();
        chk("fp_done.busy", 32'(fp_busy), 32'd0);

        chk("sb_rr_left", 32'(q_rr.size()), 32'd0);
        chk("sb_fp_left", 32'(q_fp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
